// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// State encodings, pipeline stall bit positions and the stall mask helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_ME_BUSY = 2'd2
    } arb_state_t;

    localparam int STALL_PC    = 0;
    localparam int STALL_IF_ID = 1;
    localparam int STALL_ID_EX = 2;
    localparam int STALL_EX_ME = 3;
    localparam int STALL_ME_WB = 4;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Holds every pipeline register from the PC up to and including 'last'.
    function automatic logic [4:0] stall_through(input int last);
        return 5'((1 << (last + 1)) - 1);
    endfunction

endpackage

// File: rtl/arb_bus_mux.sv
// Latches the winning requester's address/data/mask onto the memory bus and
// holds them steady until the bus completes the transfer.
module arb_bus_mux
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        grant_if,
    input  logic        grant_me,
    input  logic        release_bus,
    input  logic [31:0] if_addr,
    input  logic        me_we,
    input  logic [31:0] me_addr,
    input  logic [31:0] me_wdata,
    input  logic [3:0]  me_wmask,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask
);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ZERO_WORD;
            mem_wdata <= ZERO_WORD;
            mem_wmask <= 4'b0000;
        end else if (grant_me) begin
            mem_valid <= 1'b1;
            mem_we    <= me_we;
            mem_addr  <= me_addr;
            mem_wdata <= me_we ? me_wdata : ZERO_WORD;
            mem_wmask <= me_we ? me_wmask : 4'b0000;
        end else if (grant_if) begin
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= ZERO_WORD;
            mem_wmask <= 4'b0000;
        end else if (release_bus) begin
            // Fields stay latched; only the request is withdrawn.
            mem_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and data access,
// sequencing transfers and driving pipeline hold/bubble controls meanwhile.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ME_MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        me_req,
    input  logic        me_we,
    input  logic [31:0] me_addr,
    input  logic [31:0] me_wdata,
    input  logic [3:0]  me_wmask,
    output logic        me_done,
    output logic [31:0] me_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  stall,
    output logic        wb_bubble,
    output logic        id_bubble
);

    localparam int         BURST_W       = $clog2(ME_MAX_BURST + 1);
    localparam logic [4:0] STALL_ME_MASK = stall_through(STALL_EX_ME);
    localparam logic [4:0] STALL_IF_MASK = stall_through(STALL_IF_ID);

    arb_state_t         state;
    logic [BURST_W-1:0] burst;
    logic               drop;
    logic               starve;
    logic               grant_me;
    logic               grant_if;
    logic               complete;

    // Once ME has won ME_MAX_BURST times in a row over a waiting IF, IF goes next.
    assign starve   = if_req && (burst == BURST_W'(ME_MAX_BURST));
    assign grant_me = (state == ARB_IDLE) && me_req && !starve;
    assign grant_if = (state == ARB_IDLE) && !grant_me && if_req && !if_flush;
    assign complete = (state != ARB_IDLE) && mem_ready;

    arb_bus_mux u_bus_mux (
        .clk         (clk),
        .rst         (rst),
        .grant_if    (grant_if),
        .grant_me    (grant_me),
        .release_bus (complete),
        .if_addr     (if_addr),
        .me_we       (me_we),
        .me_addr     (me_addr),
        .me_wdata    (me_wdata),
        .me_wmask    (me_wmask),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            burst    <= '0;
            drop     <= 1'b0;
            if_done  <= 1'b0;
            me_done  <= 1'b0;
            if_rdata <= ZERO_WORD;
            me_rdata <= ZERO_WORD;
        end else begin
            if_done <= 1'b0;
            me_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_me) begin
                        state <= ARB_ME_BUSY;
                        burst <= if_req ? burst + BURST_W'(1) : '0;
                    end else if (grant_if) begin
                        state <= ARB_IF_BUSY;
                        burst <= '0;
                        drop  <= 1'b0;
                    end
                end
                ARB_IF_BUSY: begin
                    // A flushed fetch still finishes on the bus; its result is discarded.
                    if (if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ready) begin
                        state <= ARB_IDLE;
                        if (!(drop || if_flush)) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                ARB_ME_BUSY: begin
                    if (mem_ready) begin
                        state    <= ARB_IDLE;
                        me_done  <= 1'b1;
                        me_rdata <= mem_rdata;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        stall     = 5'b00000;
        wb_bubble = 1'b0;
        id_bubble = 1'b0;
        if ((me_req || state == ARB_ME_BUSY) && !me_done) begin
            stall     = STALL_ME_MASK;
            wb_bubble = 1'b1;
        end else if ((if_req || state == ARB_IF_BUSY) && !if_done) begin
            stall     = STALL_IF_MASK;
            id_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected bus issues and
// done results into queues; independent monitors pop and compare them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        me_req, me_we, me_done;
    logic [31:0] me_addr, me_wdata, me_rdata;
    logic [3:0]  me_wmask;
    logic        mem_valid, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic [4:0]  stall;
    logic        wb_bubble, id_bubble;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ME_MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .me_req    (me_req),
        .me_we     (me_we),
        .me_addr   (me_addr),
        .me_wdata  (me_wdata),
        .me_wmask  (me_wmask),
        .me_done   (me_done),
        .me_rdata  (me_rdata),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .wb_bubble (wb_bubble),
        .id_bubble (id_bubble)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_op_t;

    typedef struct packed {
        logic        we;
        logic [31:0] rdata;
    } me_exp_t;

    bus_op_t     exp_bus[$];
    bus_op_t     me_ops[$];
    me_exp_t     exp_me[$];
    logic [31:0] exp_if[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int bus_delay = 0;
    bit mon_en    = 1'b0;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_0104: return 32'h0050_0093;
            32'h0000_0108: return 32'h0000_0073;
            32'h0000_0110: return 32'h0010_0113;
            32'h0000_2000: return 32'hCAFE_F00D;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    task automatic drive_me(input bus_op_t op);
        me_req   = 1'b1;
        me_we    = op.we;
        me_addr  = op.addr;
        me_wdata = op.wdata;
        me_wmask = op.wmask;
    endtask

    // Bus slave: asserts mem_ready bus_delay cycles after it first sees mem_valid.
    initial begin
        int wc = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                wc = 0;
            end else if (mem_valid === 1'b1) begin
                if (wc >= bus_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_val(mem_addr);
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Done monitor.
    initial begin
        me_exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (if_done === 1'b1) begin
                    if (exp_if.size() == 0) chk("if_done_unexpected", 72'(if_done), 72'(0));
                    else chk("if_rdata", 72'(if_rdata), 72'(exp_if.pop_front()));
                end
                if (me_done === 1'b1) begin
                    if (exp_me.size() == 0) chk("me_done_unexpected", 72'(me_done), 72'(0));
                    else begin
                        e = exp_me.pop_front();
                        if (!e.we) chk("me_rdata", 72'(me_rdata), 72'(e.rdata));
                    end
                end
            end
        end
    end

    // Bus monitor: checks issue order/fields and stability while a transfer is open.
    initial begin
        bit      act;
        bus_op_t cap, e, cur;
        act = 1'b0;
        forever begin
            @(negedge clk);
            cur = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0, mem_wmask};
            if (mon_en && mem_valid === 1'b1) begin
                if (!act) begin
                    act = 1'b1;
                    cap = cur;
                    if (exp_bus.size() == 0) chk("bus_unexpected", 72'(mem_valid), 72'(0));
                    else begin
                        e = exp_bus.pop_front();
                        if (!e.we) e.wdata = 32'h0;
                        chk("bus_issue", 72'(cur), 72'(e));
                    end
                end else begin
                    chk("bus_stable", 72'(cur), 72'(cap));
                end
            end else begin
                act = 1'b0;
            end
        end
    end

    task automatic service(input int maxc, output int if_lat);
        int c;
        c = 0;
        if_lat = -1;
        while ((if_req || me_req) && c < maxc) begin
            @(negedge clk);
            c++;
            if (if_done) begin
                if (if_lat < 0) if_lat = c;
                if_req = 1'b0;
            end
            if (me_done) begin
                void'(me_ops.pop_front());
                if (me_ops.size() > 0) drive_me(me_ops[0]);
                else me_req = 1'b0;
            end
        end
        chk("service_timeout", 72'({if_req, me_req}), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        me_req = 1'b0; me_we = 1'b0; me_addr = 32'h0; me_wdata = 32'h0; me_wmask = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", 72'(mem_valid), 72'(0));
        chk("rst_bus", 72'({mem_we, mem_addr, mem_wdata, mem_wmask}), 72'(0));
        chk("rst_done", 72'({if_done, me_done}), 72'(0));
        chk("rst_rdata", 72'({if_rdata, me_rdata}), 72'(0));
        chk("rst_stall", 72'({stall, wb_bubble, id_bubble}), 72'(0));
        rst = 1'b0;
        mon_en = 1'b1;

        // 1: IF only, one wait cycle on the bus
        @(negedge clk);
        bus_delay = 1;
        if_addr = 32'h100; if_req = 1'b1;
        exp_bus.push_back({1'b0, 32'h100, 32'h0, 4'h0});
        exp_if.push_back(32'h0000_0013);
        #1;
        chk("t1_stall_req", 72'({stall, wb_bubble, id_bubble}), 72'({5'b00011, 1'b0, 1'b1}));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t1_stall_busy", 72'({if_done, stall}), 72'({1'b0, 5'b00011}));
        end
        @(negedge clk);
        chk("t1_done_lat", 72'(if_done), 72'(1));
        chk("t1_stall_done", 72'(stall), 72'(0));
        if_req = 1'b0;

        // 2: simultaneous IF and ME load -> ME first
        @(negedge clk);
        bus_delay = 0;
        if_addr = 32'h104; if_req = 1'b1;
        drive_me({1'b0, 32'h2000, 32'h0, 4'h0});
        exp_bus.push_back({1'b0, 32'h2000, 32'h0, 4'h0});
        exp_bus.push_back({1'b0, 32'h104, 32'h0, 4'h0});
        exp_me.push_back({1'b0, 32'hCAFE_F00D});
        exp_if.push_back(32'h0050_0093);
        #1;
        chk("t2_stall_me", 72'({stall, wb_bubble, id_bubble}), 72'({5'b01111, 1'b1, 1'b0}));
        @(negedge clk);
        chk("t2_stall_me_busy", 72'(stall), 72'(5'b01111));
        @(negedge clk);
        chk("t2_me_done", 72'(me_done), 72'(1));
        chk("t2_stall_if_wait", 72'({stall, id_bubble}), 72'({5'b00011, 1'b1}));
        me_req = 1'b0;
        @(negedge clk);
        chk("t2_stall_if_busy", 72'({if_done, stall}), 72'({1'b0, 5'b00011}));
        @(negedge clk);
        chk("t2_if_done", 72'(if_done), 72'(1));
        if_req = 1'b0;

        // 3: six stores with IF waiting -> IF takes the 5th grant
        @(negedge clk);
        bus_delay = 0;
        for (int i = 0; i < 6; i++) begin
            me_ops.push_back({1'b1, 32'h3000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF});
            exp_me.push_back({1'b1, 32'h0});
        end
        for (int i = 0; i < 4; i++) exp_bus.push_back(me_ops[i]);
        exp_bus.push_back({1'b0, 32'h108, 32'h0, 4'h0});
        exp_bus.push_back(me_ops[4]);
        exp_bus.push_back(me_ops[5]);
        exp_if.push_back(32'h0000_0073);
        drive_me(me_ops[0]);
        if_addr = 32'h108; if_req = 1'b1;
        service(100, lat);
        chk("t3_if_latency", 72'(lat), 72'(10));

        // 4a: flush while IF_BUSY -> transfer completes, no if_done
        @(negedge clk);
        bus_delay = 2;
        if_addr = 32'h10C; if_req = 1'b1;
        exp_bus.push_back({1'b0, 32'h10C, 32'h0, 4'h0});
        @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        chk("t4_stall_flushed", 72'({stall, id_bubble}), 72'({5'b00011, 1'b1}));
        @(negedge clk);
        @(negedge clk);
        chk("t4_no_if_done", 72'({if_done, mem_valid}), 72'(0));
        @(negedge clk);
        chk("t4_idle", 72'({if_done, mem_valid, stall}), 72'(0));

        // 4b: flush in IDLE suppresses the grant for one cycle
        bus_delay = 0;
        if_addr = 32'h110; if_req = 1'b1; if_flush = 1'b1;
        exp_bus.push_back({1'b0, 32'h110, 32'h0, 4'h0});
        exp_if.push_back(32'h0010_0113);
        @(negedge clk);
        chk("t4b_grant_blocked", 72'(mem_valid), 72'(0));
        if_flush = 1'b0;
        @(negedge clk);
        chk("t4b_granted", 72'(mem_valid), 72'(1));
        @(negedge clk);
        chk("t4b_if_done", 72'(if_done), 72'(1));
        if_req = 1'b0;

        // 4c: flush coincident with mem_ready drops the result
        @(negedge clk);
        bus_delay = 1;
        if_addr = 32'h114; if_req = 1'b1;
        exp_bus.push_back({1'b0, 32'h114, 32'h0, 4'h0});
        @(negedge clk);
        @(negedge clk);
        if_flush = 1'b1;
        @(negedge clk);
        chk("t4c_dropped", 72'({if_done, mem_valid}), 72'(0));
        if_flush = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("t4c_no_late_done", 72'(if_done), 72'(0));

        // 5: reset while ME_BUSY with no mem_ready
        @(negedge clk);
        bus_delay = 20;
        drive_me({1'b0, 32'h2004, 32'h0, 4'h0});
        exp_bus.push_back({1'b0, 32'h2004, 32'h0, 4'h0});
        @(negedge clk);
        chk("t5_busy", 72'({mem_valid, stall}), 72'({1'b1, 5'b01111}));
        @(negedge clk);
        rst = 1'b1; me_req = 1'b0;
        @(negedge clk);
        chk("t5_after_rst", 72'({mem_valid, stall, wb_bubble, me_done}), 72'(0));
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_me_done", 72'({me_done, mem_valid}), 72'(0));
        end

        // 6: slow masked store stays stable, following load drives wmask 0
        bus_delay = 3;
        me_ops.push_back({1'b1, 32'h4000, 32'hDEAD_BEEF, 4'b0011});
        me_ops.push_back({1'b0, 32'h2000, 32'h0, 4'h0});
        exp_bus.push_back(me_ops[0]);
        exp_bus.push_back(me_ops[1]);
        exp_me.push_back({1'b1, 32'h0});
        exp_me.push_back({1'b0, 32'hCAFE_F00D});
        drive_me(me_ops[0]);
        service(100, lat);

        repeat (3) @(negedge clk);
        chk("left_exp_bus", 72'(exp_bus.size()), 72'(0));
        chk("left_exp_if", 72'(exp_if.size()), 72'(0));
        chk("left_exp_me", 72'(exp_me.size()), 72'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
